i2c_slave_regfile: RTL

- Parametrised, synthesisable I2C slave that emulates a register-mapped sensor such as the MPU-6050.
- Replaces hand-timed SDA stimulus in benches; also usable on-FPGA as a loopback target.
- Oversamples SCL/SDA on the system clock and pulls SDA low open-drain.
- Supports register-pointer writes, auto-increment bursts, repeated START, a read-only ID register and NACK injection for error-path testing.

---
 rtl/i2c_slv_pkg.sv | 22 ++
 rtl/i2c_line_sync.sv | 47 ++++
 rtl/i2c_slave_regfile.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slv_pkg.sv
// i2c_slv_pkg: shared FSM state encoding and default identity constants
// for the I2C register-file slave.
package i2c_slv_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WR,
    S_WR_ACK,
    S_RD,
    S_RD_ACK,
    S_IGNORE
  } state_t;

  localparam logic [6:0] DEF_SLV_ADDR = 7'h68;
  localparam logic [6:0] DEF_ID_ADDR  = 7'h75;
  localparam logic [7:0] DEF_ID_VAL   = 8'h68;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: SCL/SDA synchroniser with edge and START/STOP detect.
// Ports: clk, rst_n, scl/sda pins in; sda_lvl, scl_rise/fall, start, stop out.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sh;
  logic [SYNC_STAGES-1:0] sda_sh;
  logic scl_s;
  logic sda_s;
  logic scl_q;
  logic sda_q;

  // Idle bus is high; resetting to 1 avoids a false edge on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sh <= '1;
      sda_sh <= '1;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_sh <= {scl_sh[SYNC_STAGES-2:0], scl};
      sda_sh <= {sda_sh[SYNC_STAGES-2:0], sda};
      scl_q  <= scl_s;
      sda_q  <= sda_s;
    end
  end

  assign scl_s    = scl_sh[SYNC_STAGES-1];
  assign sda_s    = sda_sh[SYNC_STAGES-1];
  assign sda_lvl  = sda_s;
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: oversampled I2C slave with a register file, ID reg,
// NACK injection, host backdoor, write strobe and transaction counter.
module i2c_slave_regfile
  import i2c_slv_pkg::*;
#(
  parameter int ADDR_I2C_SZ = 7,
  parameter int DATA_I2C_SZ = 8,
  parameter int REG_ADDR_SZ = 7,
  parameter logic [ADDR_I2C_SZ-1:0] SLV_ADDR = DEF_SLV_ADDR,
  parameter int NUM_REGS = 128,
  parameter logic [REG_ADDR_SZ-1:0] ID_ADDR = DEF_ID_ADDR,
  parameter logic [DATA_I2C_SZ-1:0] ID_VAL = DEF_ID_VAL,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   RST_n,
  input  logic                   I_SCL,
  input  logic                   I_SDA,
  output logic                   O_SDA_LOW,
  input  logic                   I_NACK_INJ,
  input  logic                   I_HOST_WE,
  input  logic [REG_ADDR_SZ-1:0] I_HOST_ADDR,
  input  logic [DATA_I2C_SZ-1:0] I_HOST_DATA,
  output logic [DATA_I2C_SZ-1:0] O_HOST_RDATA,
  output logic                   O_WR_STB,
  output logic [REG_ADDR_SZ-1:0] O_WR_ADDR,
  output logic [DATA_I2C_SZ-1:0] O_WR_DATA,
  output logic                   O_BUSY,
  output logic [7:0]             O_CNT_TRANS
);

  localparam int AB = ADDR_I2C_SZ + 1;
  localparam int SW = (AB > DATA_I2C_SZ) ? AB : DATA_I2C_SZ;
  localparam int CW = $clog2(SW + 2);
  localparam logic [CW-1:0] ALAST = CW'(AB - 1);
  localparam logic [CW-1:0] DLAST = CW'(DATA_I2C_SZ - 1);
  localparam logic [CW-1:0] DBITS = CW'(DATA_I2C_SZ);

  state_t                 state;
  logic [CW-1:0]          bit_cnt;
  logic [SW-1:0]          shift;
  logic [SW-1:0]          shift_nx;
  logic [REG_ADDR_SZ-1:0] ptr;
  logic                   rw;
  logic [DATA_I2C_SZ-1:0] cur_byte;
  logic [DATA_I2C_SZ-1:0] regs [NUM_REGS];

  logic sda_lvl;
  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (CLK),
    .rst_n   (RST_n),
    .scl     (I_SCL),
    .sda     (I_SDA),
    .sda_lvl (sda_lvl),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (start),
    .stop    (stop)
  );

  function automatic logic [DATA_I2C_SZ-1:0] rd_byte(
    input logic [REG_ADDR_SZ-1:0] a
  );
    if (a == ID_ADDR) return ID_VAL;
    if (int'(a) >= NUM_REGS) return '0;
    return regs[a];
  endfunction

  function automatic logic writable(
    input logic [REG_ADDR_SZ-1:0] a
  );
    return (a != ID_ADDR) && (int'(a) < NUM_REGS);
  endfunction

  function automatic logic [REG_ADDR_SZ-1:0] ptr_inc(
    input logic [REG_ADDR_SZ-1:0] a
  );
    return (int'(a) == NUM_REGS - 1) ? '0 : a + 1'b1;
  endfunction

  assign shift_nx     = {shift[SW-2:0], sda_lvl};
  assign cur_byte     = rd_byte(ptr);
  assign O_HOST_RDATA = rd_byte(I_HOST_ADDR);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      ptr         <= '0;
      rw          <= 1'b0;
      O_SDA_LOW   <= 1'b0;
      O_BUSY      <= 1'b0;
      O_CNT_TRANS <= '0;
      O_WR_STB    <= 1'b0;
      O_WR_ADDR   <= '0;
      O_WR_DATA   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      O_WR_STB <= 1'b0;
      // Host write first so a same-cycle bus write overrides it.
      if (I_HOST_WE && writable(I_HOST_ADDR))
        regs[I_HOST_ADDR] <= I_HOST_DATA;
      if (stop) begin
        state     <= S_IDLE;
        O_SDA_LOW <= 1'b0;
        O_BUSY    <= 1'b0;
        if (O_BUSY) O_CNT_TRANS <= O_CNT_TRANS + 8'd1;
      end else if (start) begin
        state     <= S_ADDR;
        bit_cnt   <= '0;
        O_SDA_LOW <= 1'b0;
      end else begin
        unique case (state)
          S_ADDR: if (scl_rise) begin
            shift   <= shift_nx;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == ALAST) begin
              bit_cnt <= '0;
              if (shift_nx[AB-1:1] == SLV_ADDR) begin
                O_BUSY <= 1'b1;
                rw     <= shift_nx[0];
                state  <= I_NACK_INJ ? S_IGNORE : S_ADDR_ACK;
              end else begin
                state <= S_IGNORE;
              end
            end
          end
          // ACK states: first fall pulls low, second fall releases.
          S_ADDR_ACK: if (scl_fall) begin
            if (!O_SDA_LOW) begin
              O_SDA_LOW <= 1'b1;
            end else if (rw) begin
              state     <= S_RD;
              shift     <= SW'(cur_byte);
              O_SDA_LOW <= ~cur_byte[DATA_I2C_SZ-1];
            end else begin
              state     <= S_PTR;
              O_SDA_LOW <= 1'b0;
            end
          end
          S_PTR: if (scl_rise) begin
            shift   <= shift_nx;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == DLAST) begin
              bit_cnt <= '0;
              ptr     <= shift_nx[REG_ADDR_SZ-1:0];
              state   <= S_PTR_ACK;
            end
          end
          S_PTR_ACK: if (scl_fall) begin
            if (!O_SDA_LOW) begin
              O_SDA_LOW <= 1'b1;
            end else begin
              O_SDA_LOW <= 1'b0;
              state     <= S_WR;
            end
          end
          S_WR: if (scl_rise) begin
            shift   <= shift_nx;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == DLAST) begin
              bit_cnt <= '0;
              state   <= S_WR_ACK;
              ptr     <= ptr_inc(ptr);
              if (writable(ptr)) begin
                regs[ptr] <= shift_nx[DATA_I2C_SZ-1:0];
                O_WR_STB  <= 1'b1;
                O_WR_ADDR <= ptr;
                O_WR_DATA <= shift_nx[DATA_I2C_SZ-1:0];
              end
            end
          end
          S_WR_ACK: if (scl_fall) begin
            if (!O_SDA_LOW) begin
              O_SDA_LOW <= 1'b1;
            end else begin
              O_SDA_LOW <= 1'b0;
              state     <= S_WR;
            end
          end
          // Shift advances on rise so the next fall drives shift MSB.
          S_RD: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift << 1;
            end else if (scl_fall) begin
              if (bit_cnt == DBITS) begin
                O_SDA_LOW <= 1'b0;
                state     <= S_RD_ACK;
              end else begin
                O_SDA_LOW <= ~shift[DATA_I2C_SZ-1];
              end
            end
          end
          // bit_cnt==0 marks a master ACK seen; reload on next fall.
          S_RD_ACK: begin
            if (scl_rise) begin
              if (sda_lvl) begin
                state <= S_IGNORE;
              end else begin
                ptr     <= ptr_inc(ptr);
                bit_cnt <= '0;
              end
            end else if (scl_fall && bit_cnt == '0) begin
              state     <= S_RD;
              shift     <= SW'(cur_byte);
              O_SDA_LOW <= ~cur_byte[DATA_I2C_SZ-1];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
